// File: rtl/pipeline_mem_lsu.sv
// MEM stage with a req/gnt/rvalid data-memory bus master, stall generation,
// misaligned-access and bus-timeout traps, and the M pipeline registers.
module pipeline_mem_lsu #(
    parameter int          DMEM_AW       = 10,
    parameter int          TIMEOUT_CYC   = 16,
    parameter logic [31:0] RESET_PC_PLUS = 32'h0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               valid_e_i,
    input  logic [3:0]         dmem_type_e_i,
    input  logic [31:0]        alu_calculation_e_i,
    input  logic [31:0]        rs2_e_i,
    input  logic [31:0]        alu_result_e_i,
    input  logic [31:0]        extended_imm_e_i,
    input  logic [31:0]        pc_plus_e_i,
    input  logic               reg_write_en_e_i,
    input  logic [4:0]         rd_idx_e_i,
    input  logic [3:0]         result_src_e_i,
    output logic               stall_o,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [DMEM_AW-1:0] dmem_addr_o,
    output logic [3:0]         dmem_be_o,
    output logic [31:0]        dmem_wdata_o,
    input  logic               dmem_gnt_i,
    input  logic               dmem_rvalid_i,
    input  logic [31:0]        dmem_rdata_i,
    output logic               valid_m_o,
    output logic [31:0]        mem_read_data_m_o,
    output logic [31:0]        alu_result_m_o,
    output logic [31:0]        extended_imm_m_o,
    output logic [31:0]        pc_plus_m_o,
    output logic               reg_write_en_m_o,
    output logic [4:0]         rd_idx_m_o,
    output logic [3:0]         result_src_m_o,
    output logic               misalign_m_o,
    output logic               fault_m_o,
    output logic [31:0]        trap_addr_m_o,
    output logic [31:0]        bypass_m_o
);

    localparam logic [3:0] DMEM_NO  = 4'd0;
    localparam logic [3:0] DMEM_LB  = 4'd1;
    localparam logic [3:0] DMEM_LH  = 4'd2;
    localparam logic [3:0] DMEM_LW  = 4'd3;
    localparam logic [3:0] DMEM_LBU = 4'd4;
    localparam logic [3:0] DMEM_LHU = 4'd5;
    localparam logic [3:0] DMEM_SB  = 4'd6;
    localparam logic [3:0] DMEM_SH  = 4'd7;
    localparam logic [3:0] DMEM_SW  = 4'd8;

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         off_q;
    logic [3:0]         type_q;
    logic               mem_op, is_store, misalign, access, timeout_hit;
    logic               req, stall, load_done, fault_now;
    logic [1:0]         off;

    function automatic logic [31:0] fmt_load(input logic [3:0] t, input logic [1:0] o,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{o, 3'b000} +: 8];
        h = o[1] ? d[31:16] : d[15:0];
        case (t)
            DMEM_LB:  fmt_load = {{24{b[7]}}, b};
            DMEM_LBU: fmt_load = {24'h0, b};
            DMEM_LH:  fmt_load = {{16{h[15]}}, h};
            DMEM_LHU: fmt_load = {16'h0, h};
            default:  fmt_load = d;
        endcase
    endfunction

    assign off      = alu_calculation_e_i[1:0];
    assign mem_op   = valid_e_i && (dmem_type_e_i != DMEM_NO);
    assign is_store = (dmem_type_e_i == DMEM_SB) || (dmem_type_e_i == DMEM_SH) ||
                      (dmem_type_e_i == DMEM_SW);
    assign misalign = mem_op &&
        (((dmem_type_e_i == DMEM_LW) || (dmem_type_e_i == DMEM_SW)) ? (off != 2'b00) :
         ((dmem_type_e_i == DMEM_LH) || (dmem_type_e_i == DMEM_LHU) ||
          (dmem_type_e_i == DMEM_SH)) ? off[0] : 1'b0);
    assign access      = mem_op && !misalign;
    // The counter holds completed wait cycles, so +1 includes the current one.
    assign timeout_hit = (TIMEOUT_CYC > 0) && (32'(cnt) + 32'd1 == 32'(TIMEOUT_CYC));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next = state;
        req        = 1'b0;
        stall      = 1'b0;
        load_done  = 1'b0;
        fault_now  = 1'b0;
        case (state)
            IDLE: if (access) begin
                req = 1'b1;
                if (!dmem_gnt_i) begin
                    stall      = 1'b1;
                    state_next = WAIT_GNT;
                end else if (!is_store) begin
                    stall      = 1'b1;
                    state_next = WAIT_RVALID;
                end
            end
            WAIT_GNT: if (timeout_hit) begin
                fault_now  = 1'b1;
                state_next = IDLE;
            end else begin
                req = 1'b1;
                if (!dmem_gnt_i)    stall = 1'b1;
                else if (is_store)  state_next = IDLE;
                else begin
                    stall      = 1'b1;
                    state_next = WAIT_RVALID;
                end
            end
            WAIT_RVALID: if (dmem_rvalid_i) begin
                load_done  = 1'b1;
                state_next = IDLE;
            end else if (timeout_hit) begin
                fault_now  = 1'b1;
                state_next = IDLE;
            end else begin
                stall = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: gating with resetn keeps req/stall low while reset is held, even if EXE still presents a mem op.
    assign dmem_req_o  = resetn && req;
    assign stall_o     = resetn && stall;
    assign dmem_we_o   = is_store;
    assign dmem_addr_o = alu_calculation_e_i[DMEM_AW+1:2];

    always_comb begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = rs2_e_i;
        if (dmem_type_e_i == DMEM_SB) begin
            dmem_be_o    = 4'b0001 << off;
            dmem_wdata_o = {4{rs2_e_i[7:0]}};
        end else if (dmem_type_e_i == DMEM_SH) begin
            dmem_be_o    = off[1] ? 4'b1100 : 4'b0011;
            dmem_wdata_o = {2{rs2_e_i[15:0]}};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            off_q  <= 2'b00;
            type_q <= DMEM_NO;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state <= state_next;
            if (state_next == IDLE)
                cnt <= '0;
            else if (state != IDLE && TIMEOUT_CYC > 0)
                cnt <= cnt + CNT_W'(1);
            if (req && dmem_gnt_i && !is_store) begin
                off_q  <= off;
                type_q <= dmem_type_e_i;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_m_o         <= 1'b0;
            mem_read_data_m_o <= 32'h0;
            alu_result_m_o    <= 32'h0;
            extended_imm_m_o  <= 32'h0;
            pc_plus_m_o       <= RESET_PC_PLUS;
            reg_write_en_m_o  <= 1'b0;
            rd_idx_m_o        <= 5'h0;
            result_src_m_o    <= 4'h0;
            misalign_m_o      <= 1'b0;
            fault_m_o         <= 1'b0;
            trap_addr_m_o     <= 32'h0;
        end else if (stall) begin
            valid_m_o        <= 1'b0;
            reg_write_en_m_o <= 1'b0;
            misalign_m_o     <= 1'b0;
            fault_m_o        <= 1'b0;
            trap_addr_m_o    <= 32'h0;
        end else begin
            valid_m_o        <= valid_e_i;
            alu_result_m_o   <= alu_result_e_i;
            extended_imm_m_o <= extended_imm_e_i;
            pc_plus_m_o      <= pc_plus_e_i;
            rd_idx_m_o       <= rd_idx_e_i;
            result_src_m_o   <= result_src_e_i;
            reg_write_en_m_o <= valid_e_i && reg_write_en_e_i && !misalign && !fault_now;
            misalign_m_o     <= misalign;
            fault_m_o        <= fault_now;
            trap_addr_m_o    <= (misalign || fault_now) ? alu_calculation_e_i : 32'h0;
            if (load_done)
                mem_read_data_m_o <= fmt_load(type_q, off_q, dmem_rdata_i);
        end
    end

    assign bypass_m_o = ({32{result_src_m_o[0]}} & alu_result_m_o)    |
                        ({32{result_src_m_o[1]}} & extended_imm_m_o)  |
                        ({32{result_src_m_o[2]}} & mem_read_data_m_o) |
                        ({32{result_src_m_o[3]}} & pc_plus_m_o);

endmodule

// File: doc/pipeline_mem_lsu.md
Name: pipeline_mem_lsu

Overview:
Parametrised MEM stage for the five-stage pipeline. It replaces the fixed, tightly coupled D-memory with a req/gnt/rvalid bus master, so memory latency can vary. It adds stall generation, misaligned-access trapping, a bus-timeout fault and a valid bit. It sits between EXE and WB and drives the same WB-side result fields as the existing MEM stage.

Parameters:
DMEM_AW, 10, word-address width of the D-memory bus; byte address bits [DMEM_AW+1:2] are used.
TIMEOUT_CYC, 16, cycles waited for gnt or rvalid before an access fault is raised; 0 disables the timeout.
RESET_PC_PLUS, 32'h0, reset value of pc_plus_m_o.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
valid_e_i  in  1  EXE instruction valid
dmem_type_e_i  in  4  `DMEM_* load/store type from definitions.vh
alu_calculation_e_i  in  32  effective byte address
rs2_e_i  in  32  store data
alu_result_e_i  in  32  ALU result
extended_imm_e_i  in  32  extended immediate
pc_plus_e_i  in  32  pc+4
reg_write_en_e_i  in  1  RF write enable
rd_idx_e_i  in  5  destination register
result_src_e_i  in  4  one-hot WB select: [0] alu, [1] imm, [2] mem, [3] pc+4
stall_o  out  1  hold EXE and earlier stages
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 = store
dmem_addr_o  out  DMEM_AW  word address
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-aligned store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  32  load data
valid_m_o, mem_read_data_m_o[32], alu_result_m_o[32], extended_imm_m_o[32], pc_plus_m_o[32], reg_write_en_m_o[1], rd_idx_m_o[5], result_src_m_o[4]  out  M pipeline registers
misalign_m_o  out  1  misaligned-access trap (M stage)
fault_m_o  out  1  bus-timeout trap (M stage)
trap_addr_m_o  out  32  faulting byte address
bypass_m_o  out  32  forwarding value from the M registers

Behaviour:
- Reset: async on resetn low. FSM goes to IDLE, timeout counter clears, dmem_req_o=0. All M outputs are 0 except pc_plus_m_o=RESET_PC_PLUS.
- An instruction is a mem op when valid_e_i=1 and dmem_type_e_i != `DMEM_NO.
- Misalignment rules:
  - LW/SW: addr[1:0] != 0 is misaligned.
  - LH/LHU/SH: addr[0] = 1 is misaligned.
  - LB/LBU/SB: never misaligned.
  - A misaligned access issues no request and no stall. The next edge registers misalign_m_o=1, trap_addr_m_o=address, reg_write_en_m_o=0 and valid_m_o=1.
- Bus outputs are combinational from E inputs in IDLE and WAIT_GNT:
  - dmem_addr_o = addr[DMEM_AW+1:2].
  - SB: be one-hot at addr[1:0], data replicated into that byte lane.
  - SH: be 0011 or 1100 by addr[1], data in that half-word lane.
  - SW: be 1111.
  - Loads: be 1111, we=0.
- FSM:
  - IDLE: non-mem or misaligned instruction passes through (stall_o=0). For an aligned mem op: req=1.
    - gnt=1 on a store: completes that cycle, stall_o=0.
    - gnt=1 on a load: stall_o=1, go to WAIT_RVALID.
    - gnt=0: stall_o=1, go to WAIT_GNT.
  - WAIT_GNT: req held with the same fields, stall_o=1. On gnt, a store completes (stall_o=0, go to IDLE) and a load goes to WAIT_RVALID.
  - WAIT_RVALID: req=0, stall_o=1 until rvalid.
    - In the rvalid cycle, stall_o=0 and the formatted load data is captured into mem_read_data_m_o at the next edge, returning to IDLE.
    - Load formatting uses the registered addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- rvalid is ignored outside WAIT_RVALID. gnt and rvalid in the same cycle (zero-latency load) is not allowed.
- While stall_o=1, the M registers load a bubble: valid_m_o=0, reg_write_en_m_o=0, traps=0. EXE must hold all inputs stable.
- Timeout (TIMEOUT_CYC>0): the counter counts cycles spent in WAIT_GNT or WAIT_RVALID and clears on entry to IDLE. When it reaches TIMEOUT_CYC:
  - drop req and go to IDLE with stall_o=0;
  - register fault_m_o=1, trap_addr_m_o=address and reg_write_en_m_o=0.
- bypass_m_o = OR of {32{result_src_m_o[k]}} & the matching M value (alu, imm, mem read data, pc+4).
- Reset mid-access: the outstanding transaction is abandoned and any late rvalid or gnt is ignored.

Test Plan:
- SW x=0xDEADBEEF to 0x104, gnt same cycle -> addr=0x41, be=1111, wdata=0xDEADBEEF, stall_o stays 0, valid_m_o=1 next edge.
- SB 0xA5 to 0x203, gnt after 2 cycles -> be=1000, wdata[31:24]=0xA5, stall_o=1 for exactly 2 cycles, req held stable throughout.
- LB from 0x202, rdata=0x0080_0000 with rvalid 3 cycles after gnt -> mem_read_data_m_o=0xFFFFFF80. Repeated as LBU -> 0x00000080. Bubbles (reg_write_en_m_o=0) appear during the stall.
- LH at 0x101 and SW at 0x102 -> no req, misalign_m_o=1, trap_addr_m_o=0x101 / 0x102, reg_write_en_m_o=0.
- TIMEOUT_CYC=4, gnt never asserted -> stall_o high 4 cycles then low, fault_m_o=1, FSM back in IDLE. A following ADD passes through normally.
- resetn pulsed low in WAIT_RVALID -> immediate req=0, stall_o=0, all M outputs 0. A late rvalid with 0x12345678 leaves mem_read_data_m_o at 0.
